// File: rtl/vrc_pkg.sv
// Shared constants for the vector response checker.
// FSM encoding and vector-space sizing.
package vrc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NUM_VEC = 16;
  localparam int VEC_W   = 4;

endpackage

// File: rtl/vrc_dwell_timer.sv
// Per-vector dwell counter for the response checker.
// Flags the sample cycle and the last cycle of each dwell.
module vrc_dwell_timer #(
  parameter int DWELL  = 10,
  parameter int SETTLE = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sample_tick,
  output logic o_last_tick
);

  logic [7:0] r_cnt;

  assign o_sample_tick = (r_cnt == 8'(SETTLE));
  assign o_last_tick   = (r_cnt == 8'(DWELL - 1));

  // Count 0..DWELL-1 while enabled, wrapping at the end of each dwell
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_last_tick ? 8'd0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/vector_response_checker.sv
// Self-test engine: walks all 16 input vectors onto A..D,
// samples dut_out once per vector and tallies mismatches.
module vector_response_checker
  import vrc_pkg::*;
#(
  parameter int          DWELL    = 10,
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h8000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_out,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_vec
);

  logic [1:0]       r_state;
  logic [VEC_W-1:0] r_idx;
  logic [4:0]       r_err;
  logic             r_fvalid;
  logic [VEC_W-1:0] r_fvec;

  logic w_run;
  logic w_go;
  logic w_sample;
  logic w_last;
  logic w_miss;
  logic w_last_vec;

  assign w_run      = (r_state == ST_RUN);
  assign w_go       = start && !w_run;
  assign w_last_vec = (r_idx == VEC_W'(NUM_VEC - 1));
  assign w_miss     = w_run && w_sample &&
                      (dut_out != EXPECTED[r_idx]);

  vrc_dwell_timer #(
    .DWELL  (DWELL),
    .SETTLE (SETTLE)
  ) u_timer (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clr         (w_go),
    .i_en          (w_run),
    .o_sample_tick (w_sample),
    .o_last_tick   (w_last)
  );

  // Run sequencing: start, step vector each dwell, finish after 15
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else if (w_go) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
    end else if (w_run && w_last) begin
      if (w_last_vec) begin
        r_state <= ST_DONE;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Result capture: count every miss, latch the first failing vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err    <= '0;
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
    end else if (w_go) begin
      r_err    <= '0;
      r_fvalid <= 1'b0;
      r_fvec   <= '0;
    end else if (w_miss) begin
      r_err <= r_err + 5'd1;
      if (!r_fvalid) begin
        r_fvalid <= 1'b1;
        r_fvec   <= r_idx;
      end
    end
  end

  assign {A, B, C, D} = r_idx;
  assign busy         = w_run;
  assign done         = (r_state == ST_DONE);
  assign pass         = done && (r_err == 5'd0);
  assign err_count    = r_err;
  assign fail_valid   = r_fvalid;
  assign fail_vec     = r_fvec;

endmodule

// File: tb/tb_vector_response_checker.sv
// Bench for vector_response_checker: table of fault modes,
// scoreboard of expected results, plus control corner cases.
module tb_vector_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dut_out;
  logic       A, B, C, D;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] fail_vec;

  int t = 1000;
  int mode = 0;
  int checks = 0;
  int errors = 0;
  logic g;

  typedef struct {
    int         mode;
    logic [4:0] err;
    logic       fvalid;
    logic [3:0] fvec;
    logic       pass;
  } rec_t;

  rec_t tbl[5];
  rec_t sbq[$];

  always #5 clk = ~clk;

  vector_response_checker #(
    .DWELL    (10),
    .SETTLE   (2),
    .EXPECTED (16'h8000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dut_out    (dut_out),
    .A          (A),
    .B          (B),
    .C          (C),
    .D          (D),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  // Bench-side run clock: t is the cycle index within a run
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 1000;
    else if (start && t >= 160) t <= 0;
    else if (t < 1000) t <= t + 1;
  end

  // Function under test with injectable faults
  always_comb begin
    g = A & B & C & D;
    case (mode)
      1:       dut_out = 1'b0;
      2:       dut_out = 1'b1;
      3:       dut_out = (t % 10 == 2) ? g : ~g;
      4:       dut_out = (t % 10 == 2 && t / 10 == 6) ? ~g : g;
      default: dut_out = g;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_and_check(input rec_t r, input bit poke);
    int   bsy;
    int   stepbad;
    rec_t e;
    bsy     = 0;
    stepbad = 0;
    mode    = r.mode;
    sbq.push_back(r);
    pulse_start();
    chk("clear_on_start", {done, err_count, fail_valid, fail_vec},
        32'd0);
    for (int n = 0; n < 400; n++) begin
      if (done) break;
      if (busy) bsy++;
      if (t < 160 && {A, B, C, D} !== 4'(t / 10)) stepbad++;
      start = poke && (t == 37);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_reached", done, 1);
    chk("busy_cycles", bsy, 160);
    chk("vec_stepping", stepbad, 0);
    e = sbq.pop_front();
    chk("err_count", err_count, e.err);
    chk("fail_valid", fail_valid, e.fvalid);
    chk("fail_vec", fail_vec, e.fvec);
    chk("pass", pass, e.pass);
    repeat (3) @(negedge clk);
    chk("done_hold", {busy, done, A, B, C, D}, 6'b011111);
    mode = 0;
  endtask

  initial begin
    tbl[0] = '{0, 5'd0,  1'b0, 4'h0, 1'b1};
    tbl[1] = '{1, 5'd1,  1'b1, 4'hF, 1'b0};
    tbl[2] = '{2, 5'd15, 1'b1, 4'h0, 1'b0};
    tbl[3] = '{3, 5'd0,  1'b0, 4'h0, 1'b1};
    tbl[4] = '{4, 5'd1,  1'b1, 4'h6, 1'b0};

    start = 1'b1;
    #12;
    chk("reset_outputs",
        {A, B, C, D, busy, done, pass, err_count, fail_valid, fail_vec},
        32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", {busy, done, A, B, C, D}, 32'd0);

    for (int i = 0; i < 5; i++) run_and_check(tbl[i], 1'b0);

    run_and_check(tbl[0], 1'b1);

    mode = 0;
    pulse_start();
    for (int n = 0; n < 200; n++) begin
      if (t == 55) break;
      @(negedge clk);
    end
    chk("reached_vec5", {A, B, C, D}, 4'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset",
        {A, B, C, D, busy, done, pass, err_count, fail_valid, fail_vec},
        32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_abort", {busy, done}, 32'd0);
    run_and_check(tbl[0], 1'b0);

    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_response_checker.md
Name: vector_response_checker

Overview:
- On-board self-test engine for a 4-input single-output combinational function under test.
- Sequences all 16 input combinations onto A..D and holds each for a programmable dwell.
- Samples the function output once per vector after a settle delay and compares it to a parameterised truth table.
- Reports error count, first failing vector, and pass/fail. It replaces simulation-only stimulus with a synthesizable stimulus-plus-response loop.

Parameters:
- DWELL, 10, clock cycles each vector is held (legal range 2..255).
- SETTLE, 2, cycle index within the dwell at which dut_out is sampled (legal range 1..DWELL-1).
- EXPECTED, 16'h8000, expected output per vector; bit i is the expected value for {A,B,C,D}=i.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle run request.
- dut_out  input  1  output of the function under test.
- A  output  1  stimulus bit 3 (MSB of vector index).
- B  output  1  stimulus bit 2.
- C  output  1  stimulus bit 1.
- D  output  1  stimulus bit 0.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start or reset.
- pass  output  1  done && err_count==0.
- err_count  output  5  number of mismatching vectors (0..16).
- fail_valid  output  1  a mismatch has been latched this run.
- fail_vec  output  4  vector index of the first mismatch.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; A..D=0; idx=0; cnt=0.
- States:
  - IDLE: wait for start.
  - RUN: drive the vector; cnt counts 0..DWELL-1.
  - DONE: hold results.
- IDLE + start=1: next cycle state=RUN, idx=0, cnt=0, busy=1. err_count, fail_valid and fail_vec clear on the same edge.
- RUN:
  - {A,B,C,D}=idx, registered, so the outputs change on the edge where idx changes.
  - cnt increments every cycle.
  - On the edge where cnt==SETTLE: sample dut_out.
    - If dut_out != EXPECTED[idx]: err_count+1.
    - If additionally fail_valid==0: fail_vec<=idx and fail_valid<=1.
  - Exactly one sample per vector.
  - Glitches on dut_out outside the sample cycle are ignored.
  - On the edge where cnt==DWELL-1:
    - If idx<15: idx+1 and cnt<=0.
    - If idx==15: state=DONE.
- Run length: busy is high for exactly 16*DWELL cycles. done rises on the edge after the last dwell cycle of vector 15.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - A..D hold 4'hF until the next start.
  - start=1 in DONE behaves exactly as in IDLE: done clears and a full new run begins.
- start while in RUN is ignored. No restart and no counter change.
- err_count cannot exceed 16. It is 5 bits wide and is not wrapped.
- Reset asserted mid-run: immediately returns to reset values; a partial run leaves no results.
- dut_out is assumed synchronous to clk (same-clock combinational path); no synchroniser.

Decomposition:
- Shared package vrc_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - NUM_VEC=16;
  - VEC_W=4.
- One sub-module, vrc_dwell_timer:
  - an 8-bit cnt with clear input;
  - outputs sample_tick (cnt==SETTLE) and last_tick (cnt==DWELL-1).
- The top holds the FSM, idx, compare and result registers.

Test Plan:
- Reset: hold rst_n=0 mid-clock with start=1 → all outputs 0, A..D=0. Release → remains IDLE.
- Golden run: dut_out=A&B&C&D, EXPECTED=16'h8000, DWELL=10, SETTLE=2, pulse start → busy for 160 cycles, vectors step 0..15 every 10 cycles. Then done=1, pass=1, err_count=0, fail_valid=0.
- Stuck-at-0: dut_out=0 → err_count=1, fail_vec=4'hF, fail_valid=1, pass=0.
- Stuck-at-1: dut_out=1 → err_count=15, fail_vec=4'h0, pass=0.
- Sample timing: dut_out=A&B&C&D, but forced wrong on every cycle except cnt==SETTLE → err_count=0, pass=1. Forcing wrong only at cnt==SETTLE on vector 6 → err_count=1, fail_vec=4'h6.
- Control corner cases:
  - start pulsed at cycle 37 of a run → ignored, run still ends at cycle 160.
  - start in DONE → results clear and a new 160-cycle run starts.
  - rst_n pulsed during vector 5 → all outputs 0 immediately. A subsequent start runs all 16 vectors.
